// File: rtl/iss_sched_pkg.sv
// iss_sched_pkg: decoded instruction format shared by the issue scheduler and its bus
package iss_sched_pkg;
    typedef struct packed {
        logic       branch_inst;
        logic       jmp_inst;
        logic       load_inst;
        logic       store_inst;
        logic       muldiv_inst;
        logic       alu_inst;
        logic       a_reg_valid;
        logic       b_reg_valid;
        logic [7:0] op;
        logic [4:0] rd;
    } dec_inst_t;
endpackage

// File: rtl/iss_sched_if.sv
// iss_sched_if: IQ window, unit output ports and statistics of the issue scheduler
interface iss_sched_if #(
    parameter int W             = 4,
    parameter int NUM_ALU       = 2,
    parameter int ROB_DEPTHLOG2 = 4
);
    import iss_sched_pkg::*;
    localparam int NU = NUM_ALU + 3;
    localparam int CW = $clog2(W + 1);
    typedef struct packed {
        dec_inst_t                inst;
        logic [ROB_DEPTHLOG2-1:0] rob_slot;
    } iq_entry_t;
    logic                     flush;
    logic [W-1:0]             iq_valid;
    iq_entry_t                iq_entry [W];
    logic [W-1:0]             a_ok;
    logic [W-1:0]             b_ok;
    logic [31:0]              a_val [W];
    logic [31:0]              b_val [W];
    logic                     iq_consume_en;
    logic [CW-1:0]            iq_consume_cnt;
    logic [NU-1:0]            out_valid;
    logic [NU-1:0]            out_ready;
    logic [ROB_DEPTHLOG2-1:0] out_slot [NU];
    logic [31:0]              out_a [NU];
    logic [31:0]              out_b [NU];
    dec_inst_t                out_inst [NU];
    logic [31:0]              stat_issued;
    logic [31:0]              stat_stall;
    modport master (
        output flush, iq_valid, iq_entry, a_ok, b_ok, a_val, b_val, out_ready,
        input  iq_consume_en, iq_consume_cnt, out_valid, out_slot, out_a, out_b, out_inst,
               stat_issued, stat_stall
    );
    modport slave (
        input  flush, iq_valid, iq_entry, a_ok, b_ok, a_val, b_val, out_ready,
        output iq_consume_en, iq_consume_cnt, out_valid, out_slot, out_a, out_b, out_inst,
               stat_issued, stat_stall
    );
endinterface

// File: rtl/iss_sched.sv
// iss_sched: in-order issue from a W-slot IQ window onto branch/LS/MUL/ALU ports
module iss_sched
    import iss_sched_pkg::*;
#(
    parameter int W             = 4,
    parameter bit ALU_ON_MUL    = 1'b1,
    parameter int NUM_ALU       = 2,
    parameter int ROB_DEPTHLOG2 = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    iss_sched_if.slave bus
);
    localparam int NU = NUM_ALU + 3;
    localparam int CW = $clog2(W + 1);
    localparam int SW = (W > 1) ? $clog2(W) : 1;
    localparam int PW = $clog2(NU + 1);
    localparam logic [PW-1:0] NONE = PW'(NU);

    logic [NU-1:0]            valid_q;
    logic [ROB_DEPTHLOG2-1:0] slot_q [NU];
    logic [31:0]              a_q [NU];
    logic [31:0]              b_q [NU];
    dec_inst_t                inst_q [NU];
    logic [31:0]              issued_q;
    logic [31:0]              stall_q;

    logic [NU-1:0] free;
    logic [NU-1:0] ld;
    logic [SW-1:0] src [NU];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_o;
    logic [W:0]    vext;
    logic          stop;
    logic          opnd;
    logic [PW-1:0] pick;
    dec_inst_t     e;

    assign free = ~valid_q | bus.out_ready;
    assign vext = {1'b0, bus.iq_valid};

    // In-order scan: each slot claims one free, not-yet-claimed port or halts the scan
    always_comb begin
        ld   = '0;
        cnt  = '0;
        stop = 1'b0;
        pick = NONE;
        opnd = 1'b0;
        e    = '0;
        for (int u = 0; u < NU; u++) src[u] = '0;
        for (int i = 0; i < W; i++) begin
            e    = bus.iq_entry[i].inst;
            pick = NONE;
            if (e.branch_inst || e.jmp_inst)
                pick = (vext[i+1] && free[0] && !ld[0]) ? PW'(0) : NONE;
            else if (e.load_inst || e.store_inst)
                pick = (free[1] && !ld[1]) ? PW'(1) : NONE;
            else if (e.muldiv_inst)
                pick = (free[2] && !ld[2]) ? PW'(2) : NONE;
            else if (e.alu_inst) begin
                for (int k = NU - 1; k >= 3; k--)
                    if (free[k] && !ld[k]) pick = PW'(k);
                if (pick == NONE && ALU_ON_MUL && free[2] && !ld[2]) pick = PW'(2);
            end
            opnd = (bus.a_ok[i] | ~e.a_reg_valid) & (bus.b_ok[i] | ~e.b_reg_valid);
            if (!bus.iq_valid[i] || !opnd || pick == NONE) stop = 1'b1;
            if (!stop) begin
                ld[pick]  = 1'b1;
                src[pick] = SW'(i);
                cnt       = cnt + CW'(1);
            end
        end
    end

    // Flush and reset suppress popping; loads below are gated by the same flush
    assign cnt_o              = (bus.flush || !reset_n) ? '0 : cnt;
    assign bus.iq_consume_cnt = cnt_o;
    assign bus.iq_consume_en  = |cnt_o;

    // Port registers: flush clears, issue loads, handshake drains, otherwise hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '0;
            issued_q <= '0;
            stall_q  <= '0;
            for (int u = 0; u < NU; u++) begin
                slot_q[u] <= '0;
                a_q[u]    <= '0;
                b_q[u]    <= '0;
                inst_q[u] <= '0;
            end
        end else begin
            for (int u = 0; u < NU; u++) begin
                if (bus.flush)
                    valid_q[u] <= 1'b0;
                else if (ld[u]) begin
                    valid_q[u] <= 1'b1;
                    slot_q[u]  <= bus.iq_entry[src[u]].rob_slot;
                    inst_q[u]  <= bus.iq_entry[src[u]].inst;
                    a_q[u]     <= bus.a_val[src[u]];
                    b_q[u]     <= bus.b_val[src[u]];
                end else if (bus.out_ready[u])
                    valid_q[u] <= 1'b0;
            end
            issued_q <= issued_q + 32'(cnt_o);
            stall_q  <= stall_q + 32'(bus.iq_valid[0] && cnt_o == '0 && !bus.flush);
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_slot    = slot_q;
    assign bus.out_a       = a_q;
    assign bus.out_b       = b_q;
    assign bus.out_inst    = inst_q;
    assign bus.stat_issued = issued_q;
    assign bus.stat_stall  = stall_q;
endmodule

// File: tb/tb_iss_sched.sv
// tb_iss_sched: directed scenario checks of iss_sched with W=4, NUM_ALU=2, ALU_ON_MUL=1
module tb_iss_sched;
    import iss_sched_pkg::*;
    localparam int NONE = 0, ALU = 1, MUL = 2, LD = 3, ST = 4, BR = 5, JMP = 6;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   exp_iss = 0;
    int   exp_stall = 0;

    iss_sched_if #(.W(4), .NUM_ALU(2), .ROB_DEPTHLOG2(4)) bus ();

    iss_sched #(.W(4), .ALU_ON_MUL(1'b1), .NUM_ALU(2), .ROB_DEPTHLOG2(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic dec_inst_t mk(input int cls);
        dec_inst_t d;
        d             = '0;
        d.alu_inst    = (cls == ALU);
        d.muldiv_inst = (cls == MUL);
        d.load_inst   = (cls == LD);
        d.store_inst  = (cls == ST);
        d.branch_inst = (cls == BR);
        d.jmp_inst    = (cls == JMP);
        d.a_reg_valid = 1'b1;
        d.b_reg_valid = 1'b1;
        d.op          = 8'(cls + 8'h40);
        return d;
    endfunction

    task automatic clear();
        for (int i = 0; i < 4; i++) begin
            bus.iq_valid[i] = 1'b0;
            bus.iq_entry[i] = '0;
            bus.a_ok[i]     = 1'b0;
            bus.b_ok[i]     = 1'b0;
            bus.a_val[i]    = '0;
            bus.b_val[i]    = '0;
        end
    endtask

    task automatic set_slot(input int i, input int cls, input logic [3:0] rob, input logic [31:0] a, input logic [31:0] b);
        bus.iq_valid[i]          = 1'b1;
        bus.iq_entry[i].inst     = mk(cls);
        bus.iq_entry[i].rob_slot = rob;
        bus.a_ok[i]              = 1'b1;
        bus.b_ok[i]              = 1'b1;
        bus.a_val[i]             = a;
        bus.b_val[i]             = b;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear();
        set_slot(0, ALU, 4'd1, 32'h5, 32'h6);
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.iq_consume_cnt); end
        checks++; if (bus.iq_consume_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b want 0", bus.iq_consume_en); end
        tick();
        checks++; if (bus.out_valid !== 5'b00000) begin errors++; $display("FAIL reset_valid: got %b want 00000", bus.out_valid); end
        checks++; if (bus.out_a[3] !== 32'h0 || bus.out_slot[3] !== 4'h0) begin errors++; $display("FAIL reset_data: got a=%0h slot=%0h want 0", bus.out_a[3], bus.out_slot[3]); end
        checks++; if (bus.stat_issued !== 32'd0 || bus.stat_stall !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", bus.stat_issued, bus.stat_stall); end
        clear();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_slot(0, ALU, 4'd3, 32'h11, 32'h22);
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd1 || bus.iq_consume_en !== 1'b1) begin errors++; $display("FAIL single_cnt: got %0d/%0b want 1/1", bus.iq_consume_cnt, bus.iq_consume_en); end
        exp_iss += 1;
        tick();
        clear();
        checks++; if (bus.out_valid !== 5'b01000) begin errors++; $display("FAIL single_valid: got %b want 01000", bus.out_valid); end
        checks++; if (bus.out_a[3] !== 32'h11 || bus.out_b[3] !== 32'h22 || bus.out_slot[3] !== 4'd3) begin errors++; $display("FAIL single_data: got %0h %0h %0h want 11 22 3", bus.out_a[3], bus.out_b[3], bus.out_slot[3]); end
        checks++; if (bus.out_inst[3] !== mk(ALU)) begin errors++; $display("FAIL single_inst: got %0h want %0h", bus.out_inst[3], mk(ALU)); end
        checks++; if (bus.stat_issued !== 32'(exp_iss)) begin errors++; $display("FAIL single_issued: got %0d want %0d", bus.stat_issued, exp_iss); end
        tick();
        checks++; if (bus.out_valid !== 5'b00000) begin errors++; $display("FAIL single_drain: got %b want 00000", bus.out_valid); end
    endtask

    task automatic test_dual_overflow();
        for (int i = 0; i < 3; i++) set_slot(i, ALU, 4'(i + 8), 32'h100 + 32'(i), 32'h0);
        set_slot(3, MUL, 4'd11, 32'h103, 32'h0);
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd3) begin errors++; $display("FAIL dual_cnt: got %0d want 3", bus.iq_consume_cnt); end
        exp_iss += 3;
        tick();
        clear();
        checks++; if (bus.out_valid !== 5'b11100) begin errors++; $display("FAIL dual_valid: got %b want 11100", bus.out_valid); end
        checks++; if (bus.out_a[3] !== 32'h100 || bus.out_a[4] !== 32'h101 || bus.out_a[2] !== 32'h102) begin errors++; $display("FAIL dual_route: got %0h %0h %0h want 100 101 102", bus.out_a[3], bus.out_a[4], bus.out_a[2]); end
        checks++; if (bus.stat_issued !== 32'(exp_iss)) begin errors++; $display("FAIL dual_issued: got %0d want %0d", bus.stat_issued, exp_iss); end
        set_slot(0, MUL, 4'd11, 32'h200, 32'h0);
        bus.out_ready[2] = 1'b0;
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd0) begin errors++; $display("FAIL mul_blocked_cnt: got %0d want 0", bus.iq_consume_cnt); end
        exp_stall += 1;
        tick();
        checks++; if (bus.stat_stall !== 32'(exp_stall) || bus.out_a[2] !== 32'h102) begin errors++; $display("FAIL mul_hold: got stall=%0d a=%0h want %0d 102", bus.stat_stall, bus.out_a[2], exp_stall); end
        bus.out_ready[2] = 1'b1;
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd1) begin errors++; $display("FAIL mul_drain_cnt: got %0d want 1", bus.iq_consume_cnt); end
        exp_iss += 1;
        tick();
        clear();
        checks++; if (bus.out_valid !== 5'b00100 || bus.out_a[2] !== 32'h200) begin errors++; $display("FAIL mul_reload: got %b %0h want 00100 200", bus.out_valid, bus.out_a[2]); end
        bus.out_ready[2] = 1'b0;
        for (int i = 0; i < 3; i++) set_slot(i, ALU, 4'(i), 32'h300 + 32'(i), 32'h0);
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd2) begin errors++; $display("FAIL overflow_blocked_cnt: got %0d want 2", bus.iq_consume_cnt); end
        exp_iss += 2;
        tick();
        clear();
        checks++; if (bus.out_valid !== 5'b11100 || bus.out_a[2] !== 32'h200 || bus.out_a[4] !== 32'h301) begin errors++; $display("FAIL overflow_blocked: got %b %0h %0h want 11100 200 301", bus.out_valid, bus.out_a[2], bus.out_a[4]); end
        bus.out_ready = '1;
        tick();
    endtask

    task automatic test_backpressure();
        set_slot(0, LD, 4'd5, 32'hA1, 32'hA2);
        exp_iss += 1;
        tick();
        clear();
        bus.out_ready[1] = 1'b0;
        set_slot(0, ST, 4'd6, 32'hB2, 32'hB3);
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd0) begin errors++; $display("FAIL bp_cnt: got %0d want 0", bus.iq_consume_cnt); end
        for (int c = 0; c < 2; c++) begin
            exp_stall += 1;
            tick();
            checks++; if (bus.stat_stall !== 32'(exp_stall)) begin errors++; $display("FAIL bp_stall: got %0d want %0d", bus.stat_stall, exp_stall); end
            checks++; if (bus.out_valid[1] !== 1'b1 || bus.out_a[1] !== 32'hA1 || bus.out_slot[1] !== 4'd5) begin errors++; $display("FAIL bp_hold: got %b %0h %0h want 1 a1 5", bus.out_valid[1], bus.out_a[1], bus.out_slot[1]); end
        end
        bus.out_ready[1] = 1'b1;
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd1) begin errors++; $display("FAIL bp_release_cnt: got %0d want 1", bus.iq_consume_cnt); end
        exp_iss += 1;
        tick();
        clear();
        checks++; if (bus.out_valid[1] !== 1'b1 || bus.out_a[1] !== 32'hB2 || bus.out_slot[1] !== 4'd6) begin errors++; $display("FAIL bp_no_bubble: got %b %0h %0h want 1 b2 6", bus.out_valid[1], bus.out_a[1], bus.out_slot[1]); end
        tick();
    endtask

    task automatic test_branch();
        set_slot(0, ALU, 4'd1, 32'h1, 32'h0);
        set_slot(1, BR, 4'd2, 32'h2, 32'h0);
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd1) begin errors++; $display("FAIL br_no_delay_slot: got %0d want 1", bus.iq_consume_cnt); end
        exp_iss += 1;
        tick();
        clear();
        checks++; if (bus.out_valid !== 5'b01000) begin errors++; $display("FAIL br_first_valid: got %b want 01000", bus.out_valid); end
        set_slot(0, BR, 4'd7, 32'hC0, 32'h0);
        set_slot(1, ALU, 4'd8, 32'hC1, 32'h0);
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd2) begin errors++; $display("FAIL br_with_slot_cnt: got %0d want 2", bus.iq_consume_cnt); end
        exp_iss += 2;
        tick();
        clear();
        checks++; if (bus.out_valid !== 5'b01001 || bus.out_slot[0] !== 4'd7 || bus.out_a[0] !== 32'hC0) begin errors++; $display("FAIL br_issue: got %b %0h %0h want 01001 7 c0", bus.out_valid, bus.out_slot[0], bus.out_a[0]); end
        set_slot(0, LD, 4'd1, 32'h0, 32'h0);
        set_slot(1, MUL, 4'd2, 32'h0, 32'h0);
        set_slot(2, ALU, 4'd3, 32'h0, 32'h0);
        set_slot(3, JMP, 4'd4, 32'h0, 32'h0);
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd3) begin errors++; $display("FAIL br_last_slot_cnt: got %0d want 3", bus.iq_consume_cnt); end
        exp_iss += 3;
        tick();
        clear();
        checks++; if (bus.out_valid !== 5'b01110) begin errors++; $display("FAIL br_last_slot_valid: got %b want 01110", bus.out_valid); end
        tick();
    endtask

    task automatic test_operand();
        set_slot(0, ALU, 4'd1, 32'h0, 32'h0);
        bus.a_ok[0] = 1'b0;
        set_slot(1, ALU, 4'd2, 32'h0, 32'h0);
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd0) begin errors++; $display("FAIL opnd_stall_cnt: got %0d want 0", bus.iq_consume_cnt); end
        exp_stall += 1;
        tick();
        checks++; if (bus.stat_stall !== 32'(exp_stall) || bus.out_valid !== 5'b00000) begin errors++; $display("FAIL opnd_stall: got %0d %b want %0d 00000", bus.stat_stall, bus.out_valid, exp_stall); end
        bus.iq_entry[0].inst.a_reg_valid = 1'b0;
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd2) begin errors++; $display("FAIL opnd_unused_cnt: got %0d want 2", bus.iq_consume_cnt); end
        exp_iss += 2;
        tick();
        clear();
        checks++; if (bus.out_valid !== 5'b11000) begin errors++; $display("FAIL opnd_unused_valid: got %b want 11000", bus.out_valid); end
        set_slot(0, NONE, 4'd3, 32'h0, 32'h0);
        set_slot(1, ALU, 4'd4, 32'h0, 32'h0);
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd0) begin errors++; $display("FAIL noclass_cnt: got %0d want 0", bus.iq_consume_cnt); end
        exp_stall += 1;
        tick();
        clear();
        checks++; if (bus.stat_stall !== 32'(exp_stall)) begin errors++; $display("FAIL noclass_stall: got %0d want %0d", bus.stat_stall, exp_stall); end
        tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) set_slot(i, ALU, 4'(i), 32'h0, 32'h0);
        exp_iss += 3;
        tick();
        clear();
        set_slot(0, LD, 4'd1, 32'h0, 32'h0);
        set_slot(1, ALU, 4'd2, 32'h0, 32'h0);
        set_slot(2, ALU, 4'd3, 32'h0, 32'h0);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.iq_consume_cnt !== 3'd0 || bus.iq_consume_en !== 1'b0) begin errors++; $display("FAIL flush_cnt: got %0d/%0b want 0/0", bus.iq_consume_cnt, bus.iq_consume_en); end
        tick();
        bus.flush = 1'b0;
        clear();
        checks++; if (bus.out_valid !== 5'b00000) begin errors++; $display("FAIL flush_valid: got %b want 00000", bus.out_valid); end
        checks++; if (bus.stat_issued !== 32'(exp_iss) || bus.stat_stall !== 32'(exp_stall)) begin errors++; $display("FAIL flush_stats: got %0d/%0d want %0d/%0d", bus.stat_issued, bus.stat_stall, exp_iss, exp_stall); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready[3] = 1'b0;
        set_slot(0, ALU, 4'd9, 32'h77, 32'h0);
        tick();
        clear();
        set_slot(0, LD, 4'd1, 32'h0, 32'h0);
        tick();
        checks++; if (bus.out_valid !== 5'b01010) begin errors++; $display("FAIL hold_before_reset: got %b want 01010", bus.out_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 5'b00000 || bus.out_a[3] !== 32'h0) begin errors++; $display("FAIL async_reset_valid: got %b %0h want 00000 0", bus.out_valid, bus.out_a[3]); end
        checks++; if (bus.stat_issued !== 32'd0 || bus.stat_stall !== 32'd0 || bus.iq_consume_cnt !== 3'd0) begin errors++; $display("FAIL async_reset_stats: got %0d/%0d cnt=%0d want 0/0/0", bus.stat_issued, bus.stat_stall, bus.iq_consume_cnt); end
        tick();
        clear();
        bus.out_ready = '1;
        reset_n = 1'b1;
        tick();
        checks++; if (bus.stat_issued !== 32'd0 || bus.out_valid !== 5'b00000) begin errors++; $display("FAIL post_reset: got %0d %b want 0 00000", bus.stat_issued, bus.out_valid); end
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.out_ready = '1;
        clear();
        #2;
        test_reset();
        test_single();
        test_dual_overflow();
        test_backpressure();
        test_branch();
        test_operand();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
